// File: rtl/lcd_char_feeder.sv
// LCD character feeder: queues instruction/data bytes and writes each one to an
// HD44780-style LCD slave once its busy flag clears (or the poll budget runs out).
//
// state    | meaning
// IDLE     | FIFO empty, strobes low, address 00
// POLL     | read strobe on the status register (RS=0, RW=1)
// POLL_GAP | LCD reported busy, strobes low before the next poll
// WRITE    | write strobe carrying the popped byte
// GAP      | strobes low after a write, then back to IDLE
module lcd_char_feeder #(
    parameter int E_PULSE_CYCLES = 12,
    parameter int GAP_CYCLES     = 25,
    parameter int POLL_LIMIT     = 4096,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_is_cmd,
    input  logic [7:0]                    in_data,
    output logic [1:0]                    lcd_address,
    output logic                          lcd_read,
    output logic                          lcd_write,
    output logic [7:0]                    lcd_writedata,
    input  logic [7:0]                    lcd_readdata,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          timeout_flag
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;
    localparam int CMAX = (E_PULSE_CYCLES > GAP_CYCLES) ? E_PULSE_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int PW   = $clog2(POLL_LIMIT + 1);

    localparam logic [CW-1:0] E_LAST  = CW'(E_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] G_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] P_LIMIT = PW'(POLL_LIMIT);
    localparam logic [LW-1:0] L_FULL  = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL,
        S_POLL_GAP,
        S_WRITE,
        S_GAP
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   poll_cnt_q;
    logic            lcd_read_q;
    logic            lcd_write_q;
    logic [1:0]      addr_q;
    logic [7:0]      wdata_q;
    logic            busy_q;
    logic            timeout_q;

    logic [8:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;

    logic            push;
    logic            pop;
    logic            poll_done;
    logic            rd_busy;
    logic            limit_hit;
    logic [PW-1:0]   poll_next;
    logic [8:0]      head;
    logic            unused_rd;

    // Only the busy flag of the status byte matters here.
    assign rd_busy   = lcd_readdata[7];
    assign unused_rd = ^lcd_readdata[6:0];

    // Full blocks a push even when the FSM pops in the same cycle.
    assign in_ready  = (level_q != L_FULL);
    assign push      = in_valid && in_ready;
    assign head      = mem_q[rd_ptr_q];

    assign poll_next = poll_cnt_q + PW'(1);
    assign poll_done = (state_q == S_POLL) && (cnt_q == '0);
    assign limit_hit = rd_busy && (poll_next == P_LIMIT);
    assign pop       = poll_done && (!rd_busy || limit_hit);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_is_cmd, in_data};
        end
    end

    // busy_q mirrors (next state != IDLE) || (next level != 0).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            poll_cnt_q  <= '0;
            lcd_read_q  <= 1'b0;
            lcd_write_q <= 1'b0;
            addr_q      <= 2'b00;
            wdata_q     <= 8'h00;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            busy_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    lcd_read_q  <= 1'b0;
                    lcd_write_q <= 1'b0;
                    addr_q      <= 2'b00;
                    if (level_q != '0) begin
                        state_q    <= S_POLL;
                        cnt_q      <= E_LAST;
                        poll_cnt_q <= '0;
                        lcd_read_q <= 1'b1;
                        addr_q     <= 2'b01;
                    end else begin
                        busy_q <= (level_d != '0);
                    end
                end
                S_POLL: begin
                    if (cnt_q == '0) begin
                        lcd_read_q <= 1'b0;
                        poll_cnt_q <= poll_next;
                        if (pop) begin
                            state_q     <= S_WRITE;
                            cnt_q       <= E_LAST;
                            lcd_write_q <= 1'b1;
                            addr_q      <= {~head[8], 1'b0};
                            wdata_q     <= head[7:0];
                            if (limit_hit) begin
                                timeout_q <= 1'b1;
                            end
                        end else begin
                            state_q <= S_POLL_GAP;
                            cnt_q   <= G_LAST;
                            addr_q  <= 2'b00;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_POLL_GAP: begin
                    if (cnt_q == '0) begin
                        state_q    <= S_POLL;
                        cnt_q      <= E_LAST;
                        lcd_read_q <= 1'b1;
                        addr_q     <= 2'b01;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_WRITE: begin
                    if (cnt_q == '0) begin
                        state_q     <= S_GAP;
                        cnt_q       <= G_LAST;
                        lcd_write_q <= 1'b0;
                        addr_q      <= 2'b00;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_GAP: begin
                    if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                        busy_q  <= (level_d != '0);
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cnt_q       <= '0;
                    lcd_read_q  <= 1'b0;
                    lcd_write_q <= 1'b0;
                    addr_q      <= 2'b00;
                end
            endcase
        end
    end

    assign lcd_read      = lcd_read_q;
    assign lcd_write     = lcd_write_q;
    assign lcd_address   = addr_q;
    assign lcd_writedata = wdata_q;
    assign busy          = busy_q;
    assign fifo_level    = level_q;
    assign timeout_flag  = timeout_q;

    a_no_overlap: assert property (@(posedge clk) disable iff (reset)
        !(lcd_read_q && lcd_write_q));
    a_level_max: assert property (@(posedge clk) disable iff (reset)
        level_q <= L_FULL);
    a_pop_nonempty: assert property (@(posedge clk) disable iff (reset)
        pop |-> (level_q != '0));

endmodule
